// File: rtl/chime_ctrl.sv
// chime_ctrl: hourly chime tone enables plus alarm FSM; SNOOZE state built only with CHIME_SNOOZE_EN.
// Latency: every output is a flop, updated one clk after the inputs that cause it.
// Backpressure: none; tick_1Hz and stop are single-clk pulses consumed in the clk they arrive.
module chime_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1Hz,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] alarm_hour_bcd,
    input  logic [7:0] alarm_min_bcd,
    input  logic       alarm_on,
    input  logic       stop,
    output logic       en_500,
    output logic       en_1k,
    output logic       ringing
);

`ifdef CHIME_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RING, HOLD, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RING, HOLD} state_t;
`endif

    state_t     state, state_nxt;
    logic [5:0] ring_cnt, ring_cnt_nxt;
    logic       chime_lo, chime_hi, alarm_hit, ring_nxt;
`ifdef CHIME_SNOOZE_EN
    logic [8:0] snz_cnt, snz_cnt_nxt;
    logic [1:0] snz_num, snz_num_nxt;
`endif

    assign chime_lo  = (min_bcd == 8'h59) &&
                       ((sec_bcd == 8'h51) || (sec_bcd == 8'h53) ||
                        (sec_bcd == 8'h55) || (sec_bcd == 8'h57));
    assign chime_hi  = (min_bcd == 8'h59) && (sec_bcd == 8'h59);
    assign alarm_hit = tick_1Hz && (hour_bcd == alarm_hour_bcd) &&
                       (min_bcd == alarm_min_bcd) && (sec_bcd == 8'h00);

    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
`ifdef CHIME_SNOOZE_EN
        snz_cnt_nxt  = snz_cnt;
        snz_num_nxt  = snz_num;
`endif
        if (!alarm_on) begin
            state_nxt = IDLE;
`ifdef CHIME_SNOOZE_EN
            snz_num_nxt = 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (alarm_hit) begin
                        state_nxt    = RING;
                        ring_cnt_nxt = 6'd0;
                    end
                end
                RING: begin
                    // stop outranks a coincident tick, so the count is not advanced
                    if (stop) begin
`ifdef CHIME_SNOOZE_EN
                        if (snz_num == 2'd3) begin
                            state_nxt = HOLD;
                        end else begin
                            state_nxt   = SNOOZE;
                            snz_cnt_nxt = 9'd0;
                            snz_num_nxt = snz_num + 2'd1;
                        end
`else
                        state_nxt = HOLD;
`endif
                    end else if (tick_1Hz) begin
                        ring_cnt_nxt = ring_cnt + 6'd1;
                        if (ring_cnt == 6'd59) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // parked until the alarm minute is over so it cannot retrigger
                    if (min_bcd != alarm_min_bcd) begin
                        state_nxt = IDLE;
`ifdef CHIME_SNOOZE_EN
                        snz_num_nxt = 2'd0;
`endif
                    end
                end
`ifdef CHIME_SNOOZE_EN
                SNOOZE: begin
                    if (tick_1Hz) begin
                        if (snz_cnt == 9'd299) begin
                            state_nxt    = RING;
                            ring_cnt_nxt = 6'd0;
                        end else begin
                            snz_cnt_nxt = snz_cnt + 9'd1;
                        end
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign ring_nxt = (state_nxt == RING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= 6'd0;
`ifdef CHIME_SNOOZE_EN
            snz_cnt  <= 9'd0;
            snz_num  <= 2'd0;
`endif
            en_500   <= 1'b0;
            en_1k    <= 1'b0;
            ringing  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_cnt_nxt;
`ifdef CHIME_SNOOZE_EN
            snz_cnt  <= snz_cnt_nxt;
            snz_num  <= snz_num_nxt;
`endif
            // alarm tone masks the chime so the two enables are exclusive
            en_500   <= chime_lo & ~ring_nxt;
            en_1k    <= ring_nxt | chime_hi;
            ringing  <= ring_nxt;
        end
    end

endmodule
